// File: rtl/uart_wb_pkg.sv
// uart_wb_pkg: shared types and helpers for the UART Wishbone front-end.
//   wb_state_e     : front-end FSM state encoding.
//   DATA_W_*       : the supported Wishbone data widths (8, 32, 64).
//   SEL_W_MAX      : widest byte-select vector, used to size helper inputs.
//   sel_legal      : byte select is exactly one lane or all lanes.
//   onehot_to_lane : lane index of a one-hot byte select.
package uart_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACK   = 2'd2,
        ST_DRAIN = 2'd3
    } wb_state_e;

    localparam int DATA_W_8  = 8;
    localparam int DATA_W_32 = 32;
    localparam int DATA_W_64 = 64;
    localparam int SEL_W_MAX = DATA_W_64 / 8;

    // Only the low sel_w bits are meaningful; a 1-lane bus is always legal.
    function automatic logic sel_legal(input logic [SEL_W_MAX-1:0] sel, input int sel_w);
        int ones = 0;
        for (int i = 0; i < SEL_W_MAX; i++)
            if (i < sel_w && sel[i]) ones++;
        if (sel_w <= 1) return 1'b1;
        return (ones == 1) || (ones == sel_w);
    endfunction

    function automatic int onehot_to_lane(input logic [SEL_W_MAX-1:0] oh);
        int lane = 0;
        for (int i = 0; i < SEL_W_MAX; i++)
            if (oh[i]) lane = i;
        return lane;
    endfunction

endpackage

// File: rtl/uart_wb_if_if.sv
// uart_wb_if_if: Wishbone classic bus bundle between the system bus and the
// UART front-end. Signal names are from the slave's point of view.
//   wb_cyc_i/wb_stb_i/wb_we_i : cycle, strobe, write enable
//   wb_adr_i/wb_sel_i/wb_dat_i: address, byte select, write data
//   wb_dat_o/wb_ack_o         : read data, acknowledge
//   wb_err_o                  : error response, present only with UART_WB_ERR_EN
interface uart_wb_if_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [ADDR_W-1:0] wb_adr_i;
    logic [SEL_W-1:0]  wb_sel_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack_o;
`ifdef UART_WB_ERR_EN
    logic              wb_err_o;
`endif

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
`ifdef UART_WB_ERR_EN
        , output wb_err_o
`endif
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
`ifdef UART_WB_ERR_EN
        , input wb_err_o
`endif
    );
endinterface

// File: rtl/uart_wb_lane_mux.sv
// uart_wb_lane_mux: combinational byte-lane steering.
//   sel_i   : byte select (assumed legal; all-ones maps writes to lane 0)
//   wdat_i  : Wishbone write word      -> wbyte_o : byte of the selected lane
//   rbyte_i : register read byte       -> rword_o : byte placed in its lane,
//   rwide_i : full-word read value        or rwide_i for an all-lanes select
// On an 8-bit bus the single lane is treated as a plain byte access.
module uart_wb_lane_mux
    import uart_wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W/8-1:0] sel_i,
    input  logic [DATA_W-1:0]   wdat_i,
    input  logic [7:0]          rbyte_i,
    input  logic [DATA_W-1:0]   rwide_i,
    output logic [7:0]          wbyte_o,
    output logic [DATA_W-1:0]   rword_o
);
    localparam int SEL_W = DATA_W / 8;

    logic [SEL_W_MAX-1:0]  sel_x;
    logic                  all_ones;
    int                    lane;
    logic [SEL_W-1:0][7:0] wl;
    logic [SEL_W-1:0][7:0] rl;

    assign wl = wdat_i;

    always_comb begin
        sel_x              = '0;
        sel_x[SEL_W-1:0]   = sel_i;
        all_ones           = (SEL_W > 1) && (&sel_i);
        lane               = all_ones ? 0 : onehot_to_lane(sel_x);
        wbyte_o            = '0;
        rl                 = '0;
        for (int i = 0; i < SEL_W; i++) begin
            if (i == lane) begin
                wbyte_o = wl[i];
                rl[i]   = rbyte_i;
            end
        end
        rword_o = all_ones ? rwide_i : rl;
    end
endmodule

// File: rtl/uart_wb_if.sv
// uart_wb_if: Wishbone classic slave front-end for the 8-bit UART register file.
//   clk, wb_rst_i : clock, asynchronous active-high reset
//   wb            : Wishbone slave bundle (uart_wb_if_if.slave)
//   reg_adr_o     : registered register address
//   reg_dat_o     : write byte steered from the selected lane
//   reg_dat_i     : read byte from the register file
//   reg_wide_i    : full-word read value for all-lanes selects
//   reg_we_o/re_o : one-cycle register write/read strobes
// Parameters: ADDR_W, DATA_W (8/32/64), WAIT_CYCLES (0..15).
// Build option UART_WB_ERR_EN: illegal byte selects answer with wb_err_o
// instead of wb_ack_o. Without it they are acked, reads return 0 and writes
// are dropped.
// Bus inputs are registered once; a transfer takes 3+WAIT_CYCLES cycles
// (strobe, optional wait, ack, drain).
module uart_wb_if
    import uart_wb_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    uart_wb_if_if.slave       wb,
    output logic [ADDR_W-1:0] reg_adr_o,
    output logic [7:0]        reg_dat_o,
    input  logic [7:0]        reg_dat_i,
    input  logic [DATA_W-1:0] reg_wide_i,
    output logic              reg_we_o,
    output logic              reg_re_o
);
    localparam int         SEL_W   = DATA_W / 8;
    localparam logic [3:0] WAIT_LD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // Input stage
    logic              cyc_s_q, stb_s_q, we_s_q;
    logic [ADDR_W-1:0] adr_s_q;
    logic [SEL_W-1:0]  sel_s_q;
    logic [DATA_W-1:0] dat_s_q;

    // FSM and registered responses
    wb_state_e         state_q;
    logic [3:0]        cnt_q;
    logic              ack_q;
    logic [DATA_W-1:0] dat_o_q;
`ifdef UART_WB_ERR_EN
    logic              err_q;
`endif

    logic [SEL_W_MAX-1:0] sel_x;
    logic                 legal_d, start_d, to_ack_d;
    logic [DATA_W-1:0]    rword_d;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cyc_s_q <= 1'b0;
            stb_s_q <= 1'b0;
            we_s_q  <= 1'b0;
            adr_s_q <= '0;
            sel_s_q <= '0;
            dat_s_q <= '0;
        end else begin
            cyc_s_q <= wb.wb_cyc_i;
            stb_s_q <= wb.wb_stb_i;
            we_s_q  <= wb.wb_we_i;
            adr_s_q <= wb.wb_adr_i;
            sel_s_q <= wb.wb_sel_i;
            dat_s_q <= wb.wb_dat_i;
        end
    end

    uart_wb_lane_mux #(.DATA_W(DATA_W)) u_lane_mux (
        .sel_i   (sel_s_q),
        .wdat_i  (dat_s_q),
        .rbyte_i (reg_dat_i),
        .rwide_i (reg_wide_i),
        .wbyte_o (reg_dat_o),
        .rword_o (rword_d)
    );

    always_comb begin
        sel_x            = '0;
        sel_x[SEL_W-1:0] = sel_s_q;
        legal_d          = sel_legal(sel_x, SEL_W);
        start_d          = (state_q == ST_IDLE) && cyc_s_q && stb_s_q;
        // Edge on which the response is registered: straight from IDLE when
        // there are no wait states, else at the end of the countdown.
        to_ack_d         = (start_d && (WAIT_CYCLES == 0)) ||
                           ((state_q == ST_WAIT) && cyc_s_q && (cnt_q == 4'd0));
    end

    // Strobes fire only in the IDLE cycle that accepts the request, so a
    // stb still held during DRAIN cannot re-trigger them.
    assign reg_we_o  = start_d & legal_d & we_s_q;
    assign reg_re_o  = start_d & legal_d & ~we_s_q;
    assign reg_adr_o = adr_s_q;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            dat_o_q <= '0;
`ifdef UART_WB_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef UART_WB_ERR_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        if (WAIT_CYCLES > 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_LD;
                        end else begin
                            state_q <= ST_ACK;
                        end
                    end
                end
                ST_WAIT: begin
                    // Master abort: no response, an issued strobe stands.
                    if (!cyc_s_q)            state_q <= ST_IDLE;
                    else if (cnt_q == 4'd0)  state_q <= ST_ACK;
                    else                     cnt_q   <= cnt_q - 4'd1;
                end
                ST_ACK:   state_q <= ST_DRAIN;
                default:  state_q <= ST_IDLE;
            endcase

            if (to_ack_d) begin
`ifdef UART_WB_ERR_EN
                if (legal_d) begin
                    ack_q <= 1'b1;
                    if (!we_s_q) dat_o_q <= rword_d;
                end else begin
                    err_q <= 1'b1;
                end
`else
                ack_q <= 1'b1;
                if (!we_s_q) dat_o_q <= legal_d ? rword_d : '0;
`endif
            end
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_o_q;
`ifdef UART_WB_ERR_EN
    assign wb.wb_err_o = err_q;
`endif
endmodule

// File: tb/tb_uart_wb_if.sv
// tb_uart_wb_if: directed bench for uart_wb_if. Four instances share one set
// of master inputs: u0 (32b, W=0), u2 (32b, W=2), u64 (64b, W=0), u4 (32b, W=4).
// Cycle k means the cycle after the k-th rising edge that sees the request.
module tb_uart_wb_if;
    import uart_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [2:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [7:0]  sel64;
    logic [63:0] dat64;
    logic [7:0]  rdat;
    logic [31:0] rw32;
    logic [63:0] rw64;

    logic [2:0]  radr [4];
    logic [7:0]  rdo  [4];
    logic        rwe  [4];
    logic        rre  [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_wb_if_if #(.ADDR_W(3), .DATA_W(32)) b0 ();
    uart_wb_if_if #(.ADDR_W(3), .DATA_W(32)) b2 ();
    uart_wb_if_if #(.ADDR_W(3), .DATA_W(64)) b64 ();
    uart_wb_if_if #(.ADDR_W(3), .DATA_W(32)) b4 ();

    assign b0.wb_cyc_i  = cyc;  assign b0.wb_stb_i  = stb;  assign b0.wb_we_i  = we;
    assign b0.wb_adr_i  = adr;  assign b0.wb_sel_i  = sel;  assign b0.wb_dat_i = dat;
    assign b2.wb_cyc_i  = cyc;  assign b2.wb_stb_i  = stb;  assign b2.wb_we_i  = we;
    assign b2.wb_adr_i  = adr;  assign b2.wb_sel_i  = sel;  assign b2.wb_dat_i = dat;
    assign b4.wb_cyc_i  = cyc;  assign b4.wb_stb_i  = stb;  assign b4.wb_we_i  = we;
    assign b4.wb_adr_i  = adr;  assign b4.wb_sel_i  = sel;  assign b4.wb_dat_i = dat;
    assign b64.wb_cyc_i = cyc;  assign b64.wb_stb_i = stb;  assign b64.wb_we_i = we;
    assign b64.wb_adr_i = adr;  assign b64.wb_sel_i = sel64; assign b64.wb_dat_i = dat64;

    uart_wb_if #(.ADDR_W(3), .DATA_W(32), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .wb_rst_i(rst), .wb(b0.slave), .reg_adr_o(radr[0]), .reg_dat_o(rdo[0]),
        .reg_dat_i(rdat), .reg_wide_i(rw32), .reg_we_o(rwe[0]), .reg_re_o(rre[0]));
    uart_wb_if #(.ADDR_W(3), .DATA_W(32), .WAIT_CYCLES(2)) u2 (
        .clk(clk), .wb_rst_i(rst), .wb(b2.slave), .reg_adr_o(radr[1]), .reg_dat_o(rdo[1]),
        .reg_dat_i(rdat), .reg_wide_i(rw32), .reg_we_o(rwe[1]), .reg_re_o(rre[1]));
    uart_wb_if #(.ADDR_W(3), .DATA_W(64), .WAIT_CYCLES(0)) u64 (
        .clk(clk), .wb_rst_i(rst), .wb(b64.slave), .reg_adr_o(radr[2]), .reg_dat_o(rdo[2]),
        .reg_dat_i(rdat), .reg_wide_i(rw64), .reg_we_o(rwe[2]), .reg_re_o(rre[2]));
    uart_wb_if #(.ADDR_W(3), .DATA_W(32), .WAIT_CYCLES(4)) u4 (
        .clk(clk), .wb_rst_i(rst), .wb(b4.slave), .reg_adr_o(radr[3]), .reg_dat_o(rdo[3]),
        .reg_dat_i(rdat), .reg_wide_i(rw32), .reg_we_o(rwe[3]), .reg_re_o(rre[3]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Leaves the bench just after a falling edge, ready to drive a request.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
    endtask

    logic [8:0] e_we0, e_ack0, e_we2, e_ack2;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0;
        sel64 = '0; dat64 = '0; rdat = '0; rw32 = '0; rw64 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack",  b0.wb_ack_o, 0);
        chk("rst_dat",  b0.wb_dat_o, 0);
        chk("rst_adr",  radr[0], 0);
        chk("rst_we",   rwe[0], 0);
        chk("rst_re",   rre[0], 0);
        chk("rst_st",   u0.state_q, ST_IDLE);

        // W=0 write, lane 2
        do_reset();
        cyc = 1; stb = 1; we = 1; adr = 3'd3; sel = 4'b0100; dat = 32'h00AB_0000;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("w0_we_c%0d", c), rwe[0], (c == 1));
            chk($sformatf("w0_ack_c%0d", c), b0.wb_ack_o, (c == 2));
            if (c == 1) begin
                chk("w0_wbyte", rdo[0], 8'hAB);
                chk("w0_adr", radr[0], 3'd3);
            end
            if (c == 2) drop();
        end

        // W=2 read, lane 3
        do_reset();
        cyc = 1; stb = 1; we = 0; adr = 3'd1; sel = 4'b1000; rdat = 8'h5C;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            chk($sformatf("w2_re_c%0d", c), rre[1], (c == 1));
            chk($sformatf("w2_ack_c%0d", c), b2.wb_ack_o, (c == 4));
            if (c >= 4) chk($sformatf("w2_dat_c%0d", c), b2.wb_dat_o, 32'h5C00_0000);
            if (c == 4) drop();
        end

        // 64-bit all-lanes read, then lane-5 write; read data must hold
        do_reset();
        cyc = 1; stb = 1; we = 0; sel64 = 8'hFF; rw64 = 64'h0123_4567_89AB_CDEF;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("d64_re_c%0d", c), rre[2], (c == 1));
            chk($sformatf("d64_ack_c%0d", c), b64.wb_ack_o, (c == 2));
            if (c >= 2) chk("d64_dat", b64.wb_dat_o, 64'h0123_4567_89AB_CDEF);
            if (c == 2) drop();
        end
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; sel64 = 8'h20; dat64 = 64'h0011_2233_4455_6677;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("d64w_we_c%0d", c), rwe[2], (c == 1));
            chk($sformatf("d64w_ack_c%0d", c), b64.wb_ack_o, (c == 2));
            if (c == 1) chk("d64w_wbyte", rdo[2], 8'h22);
            chk("d64w_hold", b64.wb_dat_o, 64'h0123_4567_89AB_CDEF);
            if (c == 2) drop();
        end

        // Back-to-back writes with stb held: W=0 every 3 cycles, W=2 every 5
        do_reset();
        e_we0 = 9'b001001001; e_ack0 = 9'b010010010;
        e_we2 = 9'b000100001; e_ack2 = 9'b100001000;
        cyc = 1; stb = 1; we = 1; adr = 3'd2; sel = 4'b0001; dat = 32'h0000_0011;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_we0_c%0d", c),  rwe[0],      e_we0[c-1]);
            chk($sformatf("b2b_ack0_c%0d", c), b0.wb_ack_o, e_ack0[c-1]);
            chk($sformatf("b2b_we2_c%0d", c),  rwe[1],      e_we2[c-1]);
            chk($sformatf("b2b_ack2_c%0d", c), b2.wb_ack_o, e_ack2[c-1]);
        end
        drop();

        // stb without cyc is ignored
        do_reset();
        cyc = 0; stb = 1; we = 1; sel = 4'b0001;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("nocyc_we_c%0d", c), rwe[0], 0);
            chk($sformatf("nocyc_ack_c%0d", c), b0.wb_ack_o, 0);
        end
        stb = 0;

        // Illegal selects on u0, after a legal read sets wb_dat_o
        do_reset();
        cyc = 1; stb = 1; we = 0; sel = 4'b0001; rdat = 8'h5C;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin
                chk("il_pre_dat", b0.wb_dat_o, 32'h0000_005C);
                drop();
            end
        end
        repeat (2) @(negedge clk);
        cyc = 1; stb = 1; we = 0; sel = 4'b0011; rw32 = 32'hDEAD_BEEF;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("ilr_re_c%0d", c), rre[0], 0);
            chk($sformatf("ilr_we_c%0d", c), rwe[0], 0);
`ifdef UART_WB_ERR_EN
            chk($sformatf("ilr_ack_c%0d", c), b0.wb_ack_o, 0);
            chk($sformatf("ilr_err_c%0d", c), b0.wb_err_o, (c == 2));
            chk($sformatf("ilr_dat_c%0d", c), b0.wb_dat_o, 32'h0000_005C);
`else
            chk($sformatf("ilr_ack_c%0d", c), b0.wb_ack_o, (c == 2));
            if (c >= 2) chk($sformatf("ilr_dat_c%0d", c), b0.wb_dat_o, 0);
`endif
            if (c == 2) drop();
        end
        repeat (2) @(negedge clk);
        cyc = 1; stb = 1; we = 1; sel = 4'b0000;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("ilw_we_c%0d", c), rwe[0], 0);
`ifdef UART_WB_ERR_EN
            chk($sformatf("ilw_err_c%0d", c), b0.wb_err_o, (c == 2));
            chk($sformatf("ilw_ack_c%0d", c), b0.wb_ack_o, 0);
            chk("ilw_dat", b0.wb_dat_o, 32'h0000_005C);
`else
            chk($sformatf("ilw_ack_c%0d", c), b0.wb_ack_o, (c == 2));
            chk("ilw_dat", b0.wb_dat_o, 0);
`endif
            if (c == 2) drop();
        end

        // W=4: master drops cyc in WAIT -> no ack, back to IDLE
        do_reset();
        cyc = 1; stb = 1; we = 0; sel = 4'b0001; adr = 3'd5; rdat = 8'h3C;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            chk($sformatf("ab_re_c%0d", c), rre[3], (c == 1));
            chk($sformatf("ab_ack_c%0d", c), b4.wb_ack_o, 0);
            if (c == 3) drop();
        end
        chk("ab_state", u4.state_q, ST_IDLE);
        chk("ab_dat", b4.wb_dat_o, 0);

        // W=4: reset asserted mid-WAIT clears everything at once
        do_reset();
        cyc = 1; stb = 1; we = 1; sel = 4'b0010; adr = 3'd5; dat = 32'h0000_7700;
        @(posedge clk); #1;
        chk("rw_we", rwe[3], 1);
        chk("rw_wbyte", rdo[3], 8'h77);
        chk("rw_adr", radr[3], 3'd5);
        @(posedge clk); #1;
        chk("rw_inwait", u4.state_q, ST_WAIT);
        rst = 1'b1;
        #1;
        chk("rw_state", u4.state_q, ST_IDLE);
        chk("rw_adr0", radr[3], 0);
        chk("rw_wbyte0", rdo[3], 0);
        chk("rw_we0", rwe[3], 0);
        chk("rw_re0", rre[3], 0);
        chk("rw_dat0", b4.wb_dat_o, 0);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rw_ack_c%0d", c), b4.wb_ack_o, 0);
        end
        @(negedge clk);
        cyc = 0; stb = 0; rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
